// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO edge-interrupt block: register offsets, debounce width, defaults.
// Optional debounce logic is enabled by defining GPIO_IRQ_DEBOUNCE_EN.
package gpio_irq_pkg;

  localparam logic [7:0] OFS_DATA     = 8'h00;
  localparam logic [7:0] OFS_RISE_EN  = 8'h04;
  localparam logic [7:0] OFS_FALL_EN  = 8'h08;
  localparam logic [7:0] OFS_STATUS   = 8'h0C;
  localparam logic [7:0] OFS_DEBOUNCE = 8'h10;

  localparam int DBC_W          = 16;
  localparam int DEF_NUM_GPIO   = 8;
  localparam int DEF_SETTLE_CYC = 3;

endpackage

// File: rtl/gpio_edge_irq_if.sv
// iomem valid/ready register bus shared with the per-pad GPIO cells.
interface gpio_edge_irq_if;

  logic [31:0] iomem_addr;
  logic        iomem_valid;
  logic        iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;

  modport master (
    output iomem_addr, iomem_valid, iomem_wstrb, iomem_wdata,
    input  iomem_rdata, iomem_ready
  );

  modport slave (
    input  iomem_addr, iomem_valid, iomem_wstrb, iomem_wdata,
    output iomem_rdata, iomem_ready
  );

endinterface

// File: rtl/gpio_in_filter.sv
// One pin: two-flop synchroniser followed by the filtered level register.
// With GPIO_IRQ_DEBOUNCE_EN defined, filt only follows sync2 after a sustained mismatch.
module gpio_in_filter
  import gpio_irq_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             pin_i,
`ifdef GPIO_IRQ_DEBOUNCE_EN
  input  logic [DBC_W-1:0] dbc_thresh_i,
`endif
  output logic             filt_o
);

  logic sync1_q, sync2_q, filt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [DBC_W-1:0] cnt_q, cnt_d;
  logic             filt_d;

  // >= rather than == so lowering the threshold mid-count still releases the pin.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q >= dbc_thresh_i) begin
        filt_d = sync2_q;
      end else if (cnt_q != {DBC_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) filt_q <= 1'b0;
    else         filt_q <= sync2_q;
  end
`endif

  assign filt_o = filt_q;

endmodule

// File: rtl/gpio_edge_irq.sv
// GPIO input edge detector: per-pin filter, enabled edges latched into W1C STATUS, level irq = |STATUS.
// Define GPIO_IRQ_DEBOUNCE_EN to add the DEBOUNCE register and per-pin debounce counters.
module gpio_edge_irq
  import gpio_irq_pkg::*;
#(
  parameter int          NUM_GPIO   = DEF_NUM_GPIO,
  parameter logic [31:0] BASE_ADR   = 32'h2100_0100,
  parameter int          SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                clk,
  input  logic                resetn,
  gpio_edge_irq_if.slave      bus,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic                irq
);

  localparam int SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

  logic [NUM_GPIO-1:0] filt, prev_q, rise_en_q, fall_en_q, status_q, status_d;
  logic [NUM_GPIO-1:0] edge_r, edge_f, w1c;
  logic [SW-1:0]       settle_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, acc, wr, armed;
  logic [7:0]          ofs;
  logic                unused_wdata;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [DBC_W-1:0]    dbc_q;
`endif

  for (genvar gi = 0; gi < NUM_GPIO; gi++) begin : g_pin
    gpio_in_filter u_filt (
      .clk          (clk),
      .resetn       (resetn),
      .pin_i        (gpio_in[gi]),
`ifdef GPIO_IRQ_DEBOUNCE_EN
      .dbc_thresh_i (dbc_q),
`endif
      .filt_o       (filt[gi])
    );
  end

  // One access per ack: the cycle after ready the same request is not re-accepted.
  assign acc          = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:8] == BASE_ADR[31:8]);
  assign wr           = acc && bus.iomem_wstrb;
  assign ofs          = bus.iomem_addr[7:0];
  assign unused_wdata = ^bus.iomem_wdata;

  assign edge_r   = filt & ~prev_q;
  assign edge_f   = ~filt & prev_q;
  assign armed    = (settle_q == '0);
  assign w1c      = (wr && ofs == OFS_STATUS) ? bus.iomem_wdata[NUM_GPIO-1:0] : '0;
  assign status_d = (status_q & ~w1c) |
                    ({NUM_GPIO{armed}} & ((edge_r & rise_en_q) | (edge_f & fall_en_q)));

  always_comb begin
    rdata_d = '0;
    case (ofs)
      OFS_DATA:     rdata_d[NUM_GPIO-1:0] = filt;
      OFS_RISE_EN:  rdata_d[NUM_GPIO-1:0] = rise_en_q;
      OFS_FALL_EN:  rdata_d[NUM_GPIO-1:0] = fall_en_q;
      OFS_STATUS:   rdata_d[NUM_GPIO-1:0] = status_q;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      OFS_DEBOUNCE: rdata_d[DBC_W-1:0]    = dbc_q;
`endif
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      settle_q  <= SW'(SETTLE_CYC);
`ifdef GPIO_IRQ_DEBOUNCE_EN
      dbc_q     <= '0;
`endif
    end else begin
      ready_q  <= acc;
      rdata_q  <= (acc && !bus.iomem_wstrb) ? rdata_d : '0;
      status_q <= status_d;
      prev_q   <= filt;
      if (settle_q != '0) settle_q <= settle_q - 1'b1;
      if (wr && ofs == OFS_RISE_EN) rise_en_q <= bus.iomem_wdata[NUM_GPIO-1:0];
      if (wr && ofs == OFS_FALL_EN) fall_en_q <= bus.iomem_wdata[NUM_GPIO-1:0];
`ifdef GPIO_IRQ_DEBOUNCE_EN
      if (wr && ofs == OFS_DEBOUNCE) dbc_q <= bus.iomem_wdata[DBC_W-1:0];
`endif
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign irq             = |status_q;

endmodule
